// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises host bitstream words MSB-first onto a tile
// configuration chain, tracks the chain length and reports done / framing error.
module ccff_bitstream_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              tail_sample,
    output logic              busy,
    output logic              cfg_done,
    output logic              error
);
    localparam int BL_W  = $clog2(WORD_W + 1);
    localparam int SUM_W = ((CNT_W > BL_W) ? CNT_W : BL_W) + 1;

    // Handshake: a word transfers on a cycle where word_valid && word_ready;
    // word_valid is only honoured in LOAD and word_ready never depends on it.
    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0]  bit_cnt;
    logic [BL_W-1:0]   bits_left;
    logic [WORD_W-1:0] shreg;
    logic [SUM_W-1:0]  committed;
    logic [SUM_W-1:0]  room;
    logic [BL_W-1:0]   take_n;
    logic              accept;
    logic              reaches_end;
    logic              frame_err;
    logic              last_shift;

    // bits_left includes the bit currently on ccff_head, so committed is the
    // number of chain bits already shifted or promised by accepted words.
    assign committed   = SUM_W'(bit_cnt) + SUM_W'(bits_left);
    assign room        = SUM_W'(CHAIN_LEN) - committed;
    assign reaches_end = room <= SUM_W'(WORD_W);
    assign take_n      = reaches_end ? BL_W'(room) : BL_W'(WORD_W);

    assign word_ready = (state_q == LOAD) && (bits_left <= BL_W'(1)) &&
                        (committed < SUM_W'(CHAIN_LEN));
    assign accept     = word_valid && word_ready;
    assign frame_err  = accept && (word_last != reaches_end);
    assign last_shift = ccff_shift_en && (bit_cnt == CNT_W'(CHAIN_LEN - 1));

    assign busy     = (state_q == LOAD);
    assign cfg_done = (state_q == DONE);
    assign error    = (state_q == ERR);

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD: begin
                if (frame_err) begin
                    state_d = ERR;
                end else if (last_shift) begin
                    state_d = DONE;
                end
            end
            DONE:    if (start) state_d = LOAD;
            ERR:     if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            bit_cnt       <= '0;
            bits_left     <= '0;
            shreg         <= '0;
            ccff_head     <= 1'b0;
            ccff_shift_en <= 1'b0;
            tail_sample   <= 1'b0;
        end else begin
            if (ccff_shift_en) begin
                bit_cnt     <= bit_cnt + CNT_W'(1);
                tail_sample <= ccff_tail;
            end
            if (state_q != LOAD) begin
                if (start) begin
                    bit_cnt       <= '0;
                    bits_left     <= '0;
                    ccff_shift_en <= 1'b0;
                end
            end else if (frame_err) begin
                // Offending word and any bits still in flight are dropped.
                bits_left     <= '0;
                ccff_shift_en <= 1'b0;
            end else if (accept) begin
                ccff_head     <= word_data[WORD_W-1];
                shreg         <= word_data << 1;
                bits_left     <= take_n;
                ccff_shift_en <= 1'b1;
            end else if (ccff_shift_en) begin
                if (bits_left > BL_W'(1)) begin
                    ccff_head <= shreg[WORD_W-1];
                    shreg     <= shreg << 1;
                    bits_left <= bits_left - BL_W'(1);
                end else begin
                    // Nothing queued: stall the chain, head keeps its value.
                    bits_left     <= '0;
                    ccff_shift_en <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (16-bit and 12-bit chains) checked
// every cycle against a queue-level chain model, plus literal bit-stream checks.
module tb_ccff_bitstream_loader;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;
    localparam int M_ERR  = 3;

    logic       clk = 1'b0;
    logic       prog_reset = 1'b1;
    logic       start_s[2];
    logic       wv[2];
    logic       wl[2];
    logic       tail_in[2];
    logic [7:0] wd[2];
    logic       word_ready[2];
    logic       ccff_head[2];
    logic       ccff_shift_en[2];
    logic       tail_sample[2];
    logic       busy[2];
    logic       cfg_done[2];
    logic       error[2];

    int checks = 0;
    int errors = 0;

    // Reference model: pending chain bits per instance.
    int         mode[2];
    int         shifted[2];
    int         pend_n[2];
    logic       cur_v[2];
    logic       cur_b[2];
    logic       head_l[2];
    logic       tail_e[2];
    logic [7:0] pend[2];

    // Per-cycle log: {cfg_done, word_ready, shift_en, head}
    logic [3:0] log_q0[$];
    logic [3:0] log_q1[$];
    logic       log_en[2];
    logic       exp_q[$];

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16)) u_dut0 (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start_s[0]),
        .word_valid(wv[0]), .word_data(wd[0]), .word_last(wl[0]),
        .word_ready(word_ready[0]), .ccff_head(ccff_head[0]),
        .ccff_shift_en(ccff_shift_en[0]), .ccff_tail(tail_in[0]),
        .tail_sample(tail_sample[0]), .busy(busy[0]), .cfg_done(cfg_done[0]),
        .error(error[0])
    );

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(12)) u_dut1 (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start_s[1]),
        .word_valid(wv[1]), .word_data(wd[1]), .word_last(wl[1]),
        .word_ready(word_ready[1]), .ccff_head(ccff_head[1]),
        .ccff_shift_en(ccff_shift_en[1]), .ccff_tail(tail_in[1]),
        .tail_sample(tail_sample[1]), .busy(busy[1]), .cfg_done(cfg_done[1]),
        .error(error[1])
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) tail_in[i] = 1'($urandom_range(0, 1));
    end

    // ---------------- model ----------------
    function automatic int cl(input int i);
        return (i == 0) ? 16 : 12;
    endfunction

    function automatic logic ready_exp(input int i);
        int bl;
        bl = int'(cur_v[i]) + pend_n[i];
        return (mode[i] == M_LOAD) && (bl <= 1) && (shifted[i] + bl < cl(i));
    endfunction

    task automatic model_reset(input int i);
        mode[i] = M_IDLE; shifted[i] = 0; pend_n[i] = 0; pend[i] = '0;
        cur_v[i] = 1'b0; cur_b[i] = 1'b0; head_l[i] = 1'b0; tail_e[i] = 1'b0;
    endtask

    task automatic model_step(input int i);
        int   bl;
        int   sh0;
        int   n;
        logic rdy;
        logic reach;
        bl  = int'(cur_v[i]) + pend_n[i];
        sh0 = shifted[i];
        rdy = ready_exp(i);
        if (cur_v[i]) begin
            shifted[i]++;
            tail_e[i] = tail_in[i];
            head_l[i] = cur_b[i];
        end
        if (mode[i] != M_LOAD) begin
            if (start_s[i]) begin
                mode[i] = M_LOAD; shifted[i] = 0; cur_v[i] = 1'b0; pend_n[i] = 0;
            end
        end else if (wv[i] && rdy) begin
            n = cl(i) - sh0 - bl;
            if (n > 8) n = 8;
            reach = (sh0 + bl + n == cl(i));
            if (wl[i] != reach) begin
                mode[i] = M_ERR; cur_v[i] = 1'b0; pend_n[i] = 0;
            end else begin
                cur_v[i] = 1'b1; cur_b[i] = wd[i][7];
                pend[i] = wd[i] << 1; pend_n[i] = n - 1;
            end
        end else if (cur_v[i]) begin
            if (pend_n[i] > 0) begin
                cur_b[i] = pend[i][7]; pend[i] = pend[i] << 1; pend_n[i]--;
            end else begin
                cur_v[i] = 1'b0;
            end
            if (shifted[i] == cl(i)) mode[i] = M_DONE;
        end
    endtask

    always @(posedge clk or posedge prog_reset) begin
        if (prog_reset) begin
            for (int i = 0; i < 2; i++) model_reset(i);
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("word_ready%0d", i), 32'(word_ready[i]), 32'(ready_exp(i)));
            check($sformatf("shift_en%0d", i), 32'(ccff_shift_en[i]), 32'(cur_v[i]));
            check($sformatf("head%0d", i), 32'(ccff_head[i]),
                  32'(cur_v[i] ? cur_b[i] : head_l[i]));
            check($sformatf("tail_sample%0d", i), 32'(tail_sample[i]), 32'(tail_e[i]));
            check($sformatf("busy%0d", i), 32'(busy[i]), 32'(mode[i] == M_LOAD));
            check($sformatf("cfg_done%0d", i), 32'(cfg_done[i]), 32'(mode[i] == M_DONE));
            check($sformatf("error%0d", i), 32'(error[i]), 32'(mode[i] == M_ERR));
            if (log_en[i]) begin
                if (i == 0) log_q0.push_back({cfg_done[0], word_ready[0], ccff_shift_en[0], ccff_head[0]});
                else        log_q1.push_back({cfg_done[1], word_ready[1], ccff_shift_en[1], ccff_head[1]});
            end
        end
    end

    // ---------------- driver tasks (called at negedge) ----------------
    task automatic pulse_start(input int i);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
    endtask

    task automatic send_word(input int i, input logic [7:0] d, input logic l);
        int budget;
        budget = 0;
        wv[i] = 1'b1; wd[i] = d; wl[i] = l;
        while (!word_ready[i] && budget < 64) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!word_ready[i]) begin
            errors++;
            $display("FAIL send_timeout%0d: word_ready=%0b required 1 within 64 cycles", i, word_ready[i]);
        end
        @(negedge clk);
        wv[i] = 1'b0; wl[i] = 1'b0;
    endtask

    task automatic wait_end(input int i);
        int b;
        b = 0;
        while (!(cfg_done[i] || error[i]) && b < 100) begin
            @(negedge clk);
            b++;
        end
        checks++;
        if (!(cfg_done[i] || error[i])) begin
            errors++;
            $display("FAIL end_timeout%0d: cfg_done=%0b error=%0b required one set", i, cfg_done[i], error[i]);
        end
    endtask

    task automatic log_start(input int i);
        if (i == 0) log_q0.delete(); else log_q1.delete();
        log_en[i] = 1'b1;
    endtask

    // Extracts shift count, gap cycles, shifted bits (MSB first), ready per shift
    // and whether cfg_done was high the cycle after the last shift.
    task automatic analyze(input int i, output int nshift, output int gaps,
                           output logic [31:0] bits, output logic [31:0] rdys,
                           output logic done_after);
        logic [3:0] q[$];
        int first;
        int last;
        log_en[i] = 1'b0;
        if (i == 0) q = log_q0; else q = log_q1;
        nshift = 0; gaps = 0; bits = '0; rdys = '0; first = -1; last = -1;
        done_after = 1'b0;
        foreach (q[k]) begin
            if (q[k][1]) begin
                bits = {bits[30:0], q[k][0]};
                rdys = rdys | (32'(q[k][2]) << nshift);
                nshift++;
                if (first < 0) first = k;
                last = k;
            end
        end
        if (first >= 0) begin
            for (int k = first; k <= last; k++) if (!q[k][1]) gaps++;
            if (last + 1 < q.size()) done_after = q[last + 1][3];
        end
    endtask

    task automatic check_stream(input string name, input int nshift, input logic [31:0] bits);
        check({name, "_len"}, 32'(nshift), 32'(exp_q.size()));
        for (int k = 0; k < nshift && exp_q.size() > 0; k++) begin
            check($sformatf("%s_bit%0d", name, k), 32'(bits[nshift-1-k]), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
    endtask

    task automatic push_exp(input logic [31:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) exp_q.push_back(v[k]);
    endtask

    task automatic nominal_load(input int i, input logic [7:0] a, input logic [7:0] b);
        pulse_start(i);
        send_word(i, a, 1'b0);
        send_word(i, b, 1'b1);
        wait_end(i);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- main ----------------
    initial begin : main
        int         ns;
        int         gp;
        logic [31:0] bits;
        logic [31:0] rdys;
        logic       da;
        int         nw;
        int         badk;
        logic       bad;
        logic       last;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; wv[i] = 1'b0; wl[i] = 1'b0; wd[i] = '0; log_en[i] = 1'b0;
            model_reset(i);
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(word_ready[i]), 0);
            check("rst_shift_en", 32'(ccff_shift_en[i]), 0);
            check("rst_head", 32'(ccff_head[i]), 0);
            check("rst_done", 32'(cfg_done[i]), 0);
            check("rst_error", 32'(error[i]), 0);
            check("rst_busy", 32'(busy[i]), 0);
        end
        prog_reset = 1'b0;
        repeat (2) @(negedge clk);

        // Nominal load
        log_start(0);
        nominal_load(0, 8'hA5, 8'h3C);
        analyze(0, ns, gp, bits, rdys, da);
        push_exp(32'h0000A53C, 16);
        check_stream("nominal", ns, bits);
        check("nominal_ready_bit8", 32'(rdys[7]), 1);
        check("nominal_ready_bit7", 32'(rdys[6]), 0);
        check("nominal_gaps", 32'(gp), 0);
        check("nominal_done_after", 32'(da), 1);

        // Host gaps between words
        log_start(0);
        pulse_start(0);
        send_word(0, 8'hA5, 1'b0);
        repeat (12) @(negedge clk);
        send_word(0, 8'h3C, 1'b1);
        wait_end(0);
        repeat (2) @(negedge clk);
        analyze(0, ns, gp, bits, rdys, da);
        push_exp(32'h0000A53C, 16);
        check_stream("gaps", ns, bits);
        check("gaps_count", 32'(gp), 5);
        check("gaps_done", 32'(cfg_done[0]), 1);

        // Short stream
        log_start(0);
        pulse_start(0);
        send_word(0, 8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        analyze(0, ns, gp, bits, rdys, da);
        check("short_shifts", 32'(ns), 0);
        check("short_error", 32'(error[0]), 1);
        check("short_done", 32'(cfg_done[0]), 0);
        pulse_start(0);
        check("short_restart_error", 32'(error[0]), 0);
        check("short_restart_busy", 32'(busy[0]), 1);
        send_word(0, 8'h5A, 1'b0);
        send_word(0, 8'hC3, 1'b1);
        wait_end(0);
        repeat (2) @(negedge clk);

        // Long stream
        pulse_start(0);
        send_word(0, 8'hA5, 1'b0);
        send_word(0, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        check("long_error", 32'(error[0]), 1);
        check("long_done", 32'(cfg_done[0]), 0);
        check("long_ready", 32'(word_ready[0]), 0);

        // Partial final word on the 12-bit chain
        log_start(1);
        nominal_load(1, 8'hFF, 8'h96);
        analyze(1, ns, gp, bits, rdys, da);
        push_exp(32'h00000FF9, 12);
        check_stream("partial", ns, bits);
        check("partial_done", 32'(cfg_done[1]), 1);

        // Reset mid-load
        pulse_start(0);
        send_word(0, 8'hA5, 1'b0);
        repeat (5) @(negedge clk);
        #2 prog_reset = 1'b1;
        #1;
        check("arst_shift_en", 32'(ccff_shift_en[0]), 0);
        check("arst_head", 32'(ccff_head[0]), 0);
        check("arst_busy", 32'(busy[0]), 0);
        check("arst_ready", 32'(word_ready[0]), 0);
        check("arst_tail", 32'(tail_sample[0]), 0);
        @(negedge clk);
        prog_reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(word_ready[0]), 0);
        check("post_rst_busy", 32'(busy[0]), 0);
        // start together with a valid word in IDLE: the word waits for LOAD
        log_start(0);
        wv[0] = 1'b1; wd[0] = 8'hA5; wl[0] = 1'b0;
        pulse_start(0);
        send_word(0, 8'hA5, 1'b0);
        send_word(0, 8'h3C, 1'b1);
        wait_end(0);
        repeat (2) @(negedge clk);
        analyze(0, ns, gp, bits, rdys, da);
        push_exp(32'h0000A53C, 16);
        check_stream("post_rst", ns, bits);

        // Random loads with random gaps, ignored starts and framing faults
        for (int it = 0; it < 40; it++) begin
            int i;
            i = it % 2;
            pulse_start(i);
            nw = (cl(i) + 7) / 8;
            bad = ($urandom_range(0, 3) == 0);
            badk = $urandom_range(0, nw - 1);
            for (int k = 0; k < nw; k++) begin
                last = (k == nw - 1);
                if (bad && k == badk) last = !last;
                send_word(i, 8'($urandom), last);
                if (last || (bad && k == badk)) break;
                repeat ($urandom_range(0, 3)) @(negedge clk);
                if ($urandom_range(0, 3) == 0) pulse_start(i);
            end
            wait_end(i);
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
